// File: rtl/spi_ram_slave_burst.sv
// SPI-style serial RAM slave with single-word and optional burst addressing.
// A frame is: one select bit (0 = write path, 1 = read path), then an
// (ADDR_SIZE+2)-bit word {cmd[1:0], payload}, MSB first. The command executes
// on the edge after the last bit. Command 11 then streams the read word on MISO.
// Optional feature macro: SPI_RAM_AUTO_INC_EN (address auto-increment, burst reads).
module spi_ram_slave_burst #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_err
);

    localparam int RX_W  = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(RX_W + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(RX_W);
    // Read-out runs ADDR_SIZE data edges plus one edge that returns MISO to 0.
    localparam logic [CNT_W-1:0]   RD_CNT   = CNT_W'(ADDR_SIZE + 1);
    localparam logic [ADDR_SIZE:0] DEPTH_W  = (ADDR_SIZE + 1)'(MEM_DEPTH);

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction
`endif

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [RX_W-1:0]      rx_word;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rd_addr_valid;
    logic                 done;
    logic [CNT_W-1:0]     rd_left;
    logic [ADDR_SIZE-1:0] rd_shift;

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [ADDR_SIZE-1:0] rd_word;
    logic                 ram_we;

    // Command decode, range checks and the RAM write strobe.
    always_comb begin
        cmd         = rx_word[RX_W-1:RX_W-2];
        payload     = rx_word[ADDR_SIZE-1:0];
        wr_in_range = {1'b0, wr_addr} < DEPTH_W;
        rd_in_range = {1'b0, rd_addr} < DEPTH_W;
        rd_word     = rd_in_range ? mem[rd_addr] : '0;
        ram_we      = !SS_n && !done && (bit_cnt == LAST_CNT) && (state == WRITE)
                      && (cmd == 2'b01) && wr_in_range;
    end

    // RAM array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_addr] <= payload;
        end
    end

    // Frame FSM with registered MISO and frame_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            rx_word       <= '0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            rd_addr_valid <= 1'b0;
            done          <= 1'b0;
            rd_left       <= '0;
            rd_shift      <= '0;
            MISO          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state != IDLE && SS_n) begin
                // Early SS_n release: abort without touching RAM or address state.
                state     <= IDLE;
                bit_cnt   <= '0;
                done      <= 1'b0;
                rd_left   <= '0;
                MISO      <= 1'b0;
                frame_err <= !done || (rd_left != '0);
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!SS_n) begin
                            state   <= CHK_CMD;
                            bit_cnt <= '0;
                            done    <= 1'b0;
                        end
                    end
                    CHK_CMD: begin
                        rx_word <= '0;
                        bit_cnt <= '0;
                        if (!MOSI) begin
                            state <= WRITE;
                        end else if (rd_addr_valid) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end
                    default: begin
                        if (!done) begin
                            if (bit_cnt != LAST_CNT) begin
                                rx_word <= {rx_word[RX_W-2:0], MOSI};
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                done <= 1'b1;
                                if (state == WRITE) begin
                                    if (cmd == 2'b00) begin
                                        wr_addr <= payload;
                                    end
`ifdef SPI_RAM_AUTO_INC_EN
                                    if (cmd == 2'b01) begin
                                        wr_addr <= next_addr(wr_addr);
                                    end
`endif
                                end else if (cmd == 2'b10) begin
                                    rd_addr       <= payload;
                                    rd_addr_valid <= 1'b1;
                                end else if (cmd == 2'b11 && state == READ_DATA) begin
                                    rd_shift <= rd_word;
                                    rd_left  <= RD_CNT;
                                end
                            end
                        end else if (rd_left != '0) begin
                            rd_left <= rd_left - 1'b1;
                            if (rd_left != CNT_W'(1)) begin
                                MISO     <= rd_shift[ADDR_SIZE-1];
                                rd_shift <= {rd_shift[ADDR_SIZE-2:0], 1'b0};
                            end else begin
                                MISO <= 1'b0;
`ifdef SPI_RAM_AUTO_INC_EN
                                rd_addr <= next_addr(rd_addr);
`else
                                rd_addr_valid <= 1'b0;
`endif
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Scoreboard bench for spi_ram_slave_burst: the frame driver pushes the
// expected per-edge MISO/frame_err pair from a frame-level model; a monitor
// pops and compares one entry after every clock edge.
module tb_spi_ram_slave_burst;

    localparam int DEPTH = 200;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst_n, ss_n, mosi, miso, frame_err;

    always #5 clk = ~clk;

    spi_ram_slave_burst #(
        .MEM_DEPTH(DEPTH),
        .ADDR_SIZE(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic miso;
        logic ferr;
    } exp_t;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string tag      = "reset";

    // Reference model state
    logic [7:0] ram_m [DEPTH];
    logic [7:0] m_wr, m_rd;
    bit         m_valid;

    function automatic logic [7:0] inc(input logic [7:0] a);
        return (int'(a) == DEPTH - 1) ? 8'd0 : a + 8'd1;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%s]: got %b, expected %b", name, tag, act, exp);
    endtask

    // One clock edge of stimulus; called at posedge+2.
    task automatic step(input logic ss, input logic d, input logic em, input logic ef);
        exp_t e;
        ss_n   = ss;
        mosi   = d;
        e.miso = em;
        e.ferr = ef;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Drive one frame. low < 0: full frame; otherwise SS_n rises after `low`
    // selected edges. rst_at >= 0: reset is asserted after that many edges instead.
    task automatic frame(input logic sel, input logic [9:0] w, input int low,
                         input int rst_at);
        logic [1:0] cmd;
        logic [7:0] rdata;
        bit         is_read, err;
        int         total, len;
        logic       d, em;
        cmd     = w[9:8];
        is_read = sel && m_valid && (cmd == 2'b11);
        rdata   = (int'(m_rd) < DEPTH) ? ram_m[m_rd] : 8'h00;
        total   = is_read ? 22 : 13;
        len     = (rst_at >= 0) ? rst_at : ((low < 0 || low > total) ? total : low);
        for (int k = 0; k < len; k++) begin
            if (k == 1) d = sel;
            else if (k >= 2 && k <= 11) d = w[11-k];
            else d = 1'($urandom);
            em = (is_read && k >= 13 && k <= 20) ? rdata[20-k] : 1'b0;
            step(1'b0, d, em, 1'b0);
        end
        if (rst_at >= 0) begin
            rst_n = 1'b0;
            ss_n  = 1'b1;
            #1;
            check("miso_async_rst", miso, 1'b0);
            check("ferr_async_rst", frame_err, 1'b0);
            repeat (2) @(posedge clk);
            #2;
            rst_n   = 1'b1;
            m_wr    = 8'd0;
            m_rd    = 8'd0;
            m_valid = 1'b0;
            return;
        end
        err = (len >= 1) && (len <= 12 || (is_read && len <= 21));
        step(1'b1, 1'($urandom), 1'b0, err);
        if (len >= 13) begin
            if (!sel) begin
                if (cmd == 2'b00) begin
                    m_wr = w[7:0];
                end else if (cmd == 2'b01) begin
                    if (int'(m_wr) < DEPTH) ram_m[m_wr] = w[7:0];
`ifdef SPI_RAM_AUTO_INC_EN
                    m_wr = inc(m_wr);
`endif
                end
            end else if (cmd == 2'b10) begin
                m_rd    = w[7:0];
                m_valid = 1'b1;
            end
        end
        if (is_read && len >= 22) begin
`ifdef SPI_RAM_AUTO_INC_EN
            m_rd = inc(m_rd);
`else
            m_valid = 1'b0;
`endif
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("miso", miso, e.miso);
                check("frame_err", frame_err, e.ferr);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic sel;
        logic [1:0] cmd;
        int low;
        rst_n = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("miso_reset", miso, 1'b0);
        check("ferr_reset", frame_err, 1'b0);
        #1;
        rst_n   = 1'b1;
        m_wr    = 8'd0;
        m_rd    = 8'd0;
        m_valid = 1'b0;

        tag = "read_no_addr";
        frame(1'b1, {2'b11, 8'h5A}, -1, -1);

        tag = "fill";
        for (int a = 0; a < DEPTH; a++) begin
            frame(1'b0, {2'b00, 8'(a)}, -1, -1);
            frame(1'b0, {2'b01, 8'($urandom)}, -1, -1);
        end

        tag = "write_then_read";
        frame(1'b0, {2'b00, 8'd5}, -1, -1);
        frame(1'b0, {2'b01, 8'd7}, -1, -1);
        frame(1'b1, {2'b10, 8'd5}, -1, -1);
        frame(1'b1, {2'b11, 8'hC3}, -1, -1);

        tag = "abort_write";
        frame(1'b0, {2'b00, 8'd5}, -1, -1);
        frame(1'b0, {2'b01, 8'hAA}, 7, -1);
        frame(1'b1, {2'b10, 8'd5}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);

        tag = "out_of_range";
        frame(1'b0, {2'b00, 8'd200}, -1, -1);
        frame(1'b0, {2'b01, 8'hFF}, -1, -1);
        frame(1'b1, {2'b10, 8'd200}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);

        tag = "wrap_burst";
        frame(1'b0, {2'b00, 8'd198}, -1, -1);
        frame(1'b0, {2'b01, 8'h11}, -1, -1);
        frame(1'b0, {2'b01, 8'h22}, -1, -1);
        frame(1'b0, {2'b01, 8'h33}, -1, -1);
        frame(1'b1, {2'b10, 8'd198}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);
        frame(1'b1, {2'b10, 8'd0}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);

        tag = "reset_mid_read";
        frame(1'b0, {2'b00, 8'd10}, -1, -1);
        frame(1'b0, {2'b01, 8'hFF}, -1, -1);
        frame(1'b1, {2'b10, 8'd10}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, 16);
        frame(1'b1, {2'b10, 8'd10}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);

        tag = "abort_readout";
        frame(1'b1, {2'b10, 8'd20}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, 17, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);

        tag = "wrong_top_bit";
        frame(1'b0, {2'b10, 8'd3}, -1, -1);
        frame(1'b1, {2'b01, 8'h99}, -1, -1);
        frame(1'b1, {2'b11, 8'h00}, -1, -1);

        tag = "random";
        for (int i = 0; i < 300; i++) begin
            sel    = 1'($urandom);
            cmd[1] = ($urandom_range(0, 3) == 0) ? ~sel : sel;
            cmd[0] = 1'($urandom);
            low    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 22)) : -1;
            frame(sel, {cmd, 8'($urandom_range(0, 219))}, low, -1);
        end

        tag = "drain";
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("queue_drained", 1'(q.size() == 0), 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_slave_burst.md
SPI_RAM_SLAVE_BURST -- requirements
Module: spi_ram_slave_burst

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, number of RAM words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, which sets both the address width and the data width; MEM_DEPTH SHALL be <= 2**ADDR_SIZE.
REQ-003 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port SS_n, input, 1 bit: slave select, active-low; high frames the link idle.
REQ-006 Port MOSI, input, 1 bit: serial data in, MSB first, sampled on clk rising edge.
REQ-007 Port MISO, output, 1 bit: serial read data out, MSB first, registered.
REQ-008 Port frame_err, output, 1 bit: one-cycle pulse when SS_n rises before a frame completes.

Function
REQ-009 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-010 IDLE->CHK_CMD occurs on the first edge with SS_n=0.
REQ-011 CHK_CMD samples MOSI: 0->WRITE; 1->READ_DATA if rd_addr_valid=1, else READ_ADD.
REQ-012 In WRITE, READ_ADD and READ_DATA the block SHALL shift MOSI into an (ADDR_SIZE+2)-bit rx_word, MSB first, over exactly ADDR_SIZE+2 cycles counted by a bit counter.
REQ-013 Command decode from rx_word[ADDR_SIZE+1:ADDR_SIZE]:
  - 00: load wr_addr.
  - 01: write payload to ram[wr_addr].
  - 10: load rd_addr and set rd_addr_valid.
  - 11: read ram[rd_addr]; payload is ignored.
REQ-014 The decoded action SHALL execute on the edge after the last bit, which is a 1-cycle latency.
REQ-015 A command whose top bit disagrees with the state is ignored with no RAM or address-register change. Top bit 1 in WRITE is ignored. Top bit 0 in READ_ADD or READ_DATA is ignored.
REQ-016 Command 11 SHALL register ram[rd_addr] on the execute edge.
REQ-017 After command 11 executes, MISO SHALL present the read word MSB first for ADDR_SIZE consecutive cycles, starting on the following edge.
REQ-018 After the last read bit, MISO SHALL return to 0 and rd_addr_valid SHALL clear; the FSM remains in READ_DATA until SS_n=1.
REQ-019 Any state other than IDLE SHALL go to IDLE on the edge where SS_n=1, and the bit counter SHALL clear.
REQ-020 frame_err SHALL pulse for one cycle if SS_n rises in CHK_CMD, or before the command executes, or while read data is still shifting; SS_n rising in IDLE or after completion raises no error.
REQ-021 An aborted frame SHALL leave RAM, wr_addr, rd_addr and rd_addr_valid unchanged.
REQ-022 A write to an address >= MEM_DEPTH SHALL be discarded, and a read from an address >= MEM_DEPTH SHALL return all zeros.
REQ-023 MISO SHALL be 0 whenever the block is not shifting read data.

Reset
REQ-024 On rst_n=0 the block SHALL asynchronously force: state=IDLE, counter=0, rx_word=0, wr_addr=0, rd_addr=0, rd_addr_valid=0, MISO=0, frame_err=0.
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no RAM write and no frame_err pulse.

Configuration
REQ-027 With macro SPI_RAM_AUTO_INC_EN defined, wr_addr SHALL increment after each command 01, and rd_addr SHALL increment after each command 11 completes its read-out.
REQ-028 Under SPI_RAM_AUTO_INC_EN, both addresses SHALL wrap from MEM_DEPTH-1 to 0, and rd_addr_valid SHALL stay set after read-out, enabling burst reads.
REQ-029 Without SPI_RAM_AUTO_INC_EN, the addresses SHALL change only via commands 00 and 10, and REQ-018 applies.

Verification
REQ-030 Write then read: frames 00_00000101 then 01_00000111, then 10_00000101 and 11_xxxxxxxx -> MISO shifts 00000111 over 8 cycles, then MISO=0.
REQ-031 Abort: SS_n rises after 5 bits of 01_10101010 -> frame_err pulses once; the RAM word is unchanged; the next frame is decoded normally.
REQ-032 Out of range (MEM_DEPTH=200): write 0xFF to address 200, then read address 200 -> reads 00000000.
REQ-033 Auto-increment with SPI_RAM_AUTO_INC_EN: wr_addr=254; write 0x11 then 0x22 then 0x33 -> RAM[254]=0x11, RAM[255]=0x22, RAM[0]=0x33; two command-11 frames after rd_addr=254 read 0x11 then 0x22.
REQ-034 Reset in READ_DATA after 3 MISO bits -> MISO=0 immediately and state=IDLE; RAM contents are retained.
REQ-035 Read with no prior rd_addr: CHK_CMD MOSI=1 with rd_addr_valid=0 -> READ_ADD is entered; frame 11_xxxxxxxx is ignored and MISO stays 0.
